// File: rtl/leds_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : leds_pkg                                                        |
// | Purpose  : Shared mode encodings and width helper for the LED engine.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package leds_pkg;

    localparam logic [1:0] MODE_BOUNCE = 2'b00;
    localparam logic [1:0] MODE_WRAP   = 2'b01;
    localparam logic [1:0] MODE_FILL   = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    // Ceiling log2; clog2(1) is 0, so callers size counters for value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >>> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/leds_scanner_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : leds_scanner_multi_if                                           |
// | Purpose  : Control inputs and LED outputs of the pattern engine.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface leds_scanner_multi_if #(
    parameter int NUM_LEDS = 8
);
    logic                enable;
    logic [1:0]          mode;
    logic [1:0]          speed;
    logic [NUM_LEDS-1:0] leds;
    logic                step_pulse;
    logic                at_end;

    // master: switches / control register side; slave: the LED engine.
    modport master (
        output enable, mode, speed,
        input  leds, step_pulse, at_end
    );

    modport slave (
        input  enable, mode, speed,
        output leds, step_pulse, at_end
    );
endinterface
`default_nettype wire

// File: rtl/leds_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : leds_tick_gen                                                   |
// | Purpose  : Prescaler producing one step tick every max(1, D >> speed).     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module leds_tick_gen #(
    parameter int unsigned DELAY_TICKS = 50_000_000,
    parameter int          CNT_W       = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] speed,
    output logic       tick
);

    localparam logic [CNT_W-1:0] c_delay = CNT_W'(DELAY_TICKS);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_shifted;
    logic [CNT_W-1:0] w_period_m1;
    logic             w_tick;

    // A shift to zero clamps the period to one cycle (period-1 = 0).
    // Comparing with >= lets a shortened period fire at once instead of
    // waiting for the counter to wrap.
    always_comb begin
        w_shifted   = c_delay >> speed;
        w_period_m1 = (w_shifted == '0) ? '0 : (w_shifted - c_one);
        w_tick      = enable && (r_cnt >= w_period_m1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign tick = w_tick;

endmodule
`default_nettype wire

// File: rtl/leds_scanner_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : leds_scanner_multi                                              |
// | Purpose  : LED pattern engine: bounce, wrap, fill bar and blink-all.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module leds_scanner_multi #(
    parameter int          NUM_LEDS    = 8,
    parameter int unsigned DELAY_TICKS = 50_000_000,
    parameter int          CNT_W       = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    leds_scanner_multi_if.slave   bus
);
    import leds_pkg::*;

    localparam int POS_W = clog2(NUM_LEDS + 1);
    localparam logic [POS_W-1:0] c_pos_one  = POS_W'(1);
    localparam logic [POS_W-1:0] c_pos_last = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0] c_pos_full = POS_W'(NUM_LEDS);
    localparam logic [NUM_LEDS-1:0] c_led0  = NUM_LEDS'(1);

    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;

    logic                w_tick;
    logic [1:0]          r_mode;
    logic [POS_W-1:0]    r_pos;
    logic [0:0]          r_dir;
    logic [NUM_LEDS-1:0] r_leds;
    logic                r_step_pulse;
    logic                r_at_end;

    logic [POS_W-1:0]    w_pos;
    logic [0:0]          w_dir;
    logic [NUM_LEDS-1:0] w_leds;
    logic                w_at_end;

    function automatic logic [NUM_LEDS-1:0] one_hot(input logic [POS_W-1:0] pos);
        logic [NUM_LEDS-1:0] v;
        for (int i = 0; i < NUM_LEDS; i++) begin
            v[i] = (POS_W'(i) == pos);
        end
        return v;
    endfunction

    function automatic logic [NUM_LEDS-1:0] bar(input logic [POS_W-1:0] level);
        logic [NUM_LEDS-1:0] v;
        for (int i = 0; i < NUM_LEDS; i++) begin
            v[i] = (POS_W'(i) < level);
        end
        return v;
    endfunction

    leds_tick_gen #(
        .DELAY_TICKS (DELAY_TICKS),
        .CNT_W       (CNT_W)
    ) u_tick_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (bus.enable),
        .speed   (bus.speed),
        .tick    (w_tick)
    );

    // Next pattern state, consumed only on a tick. A mode change restarts
    // the newly selected pattern rather than advancing the old one.
    always_comb begin
        w_pos  = r_pos;
        w_dir  = r_dir;
        w_leds = r_leds;
        if (bus.mode != r_mode) begin
            w_pos = '0;
            w_dir = DIR_UP;
            case (bus.mode)
                MODE_FILL:  w_leds = '0;
                MODE_BLINK: w_leds = '1;
                default:    w_leds = c_led0;
            endcase
        end else begin
            case (r_mode)
                MODE_BOUNCE: begin
                    if (r_dir == DIR_UP) begin
                        w_pos = r_pos + c_pos_one;
                        if (w_pos == c_pos_last) begin
                            w_dir = DIR_DOWN;
                        end
                    end else begin
                        w_pos = r_pos - c_pos_one;
                        if (w_pos == '0) begin
                            w_dir = DIR_UP;
                        end
                    end
                    w_leds = one_hot(w_pos);
                end
                MODE_WRAP: begin
                    w_pos  = (r_pos >= c_pos_last) ? '0 : (r_pos + c_pos_one);
                    w_leds = one_hot(w_pos);
                end
                MODE_FILL: begin
                    w_pos  = (r_pos >= c_pos_full) ? '0 : (r_pos + c_pos_one);
                    w_leds = bar(w_pos);
                end
                default: begin
                    w_leds = ~r_leds;
                end
            endcase
        end
    end

    // The mode register always takes bus.mode on a tick, so the terminal
    // test is made against the incoming mode.
    always_comb begin
        w_at_end = 1'b0;
        case (bus.mode)
            MODE_BOUNCE, MODE_WRAP: w_at_end = (w_pos == c_pos_last);
            MODE_FILL:              w_at_end = (w_pos == c_pos_full);
            default:                w_at_end = (w_leds == '0);
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mode       <= MODE_BOUNCE;
            r_pos        <= '0;
            r_dir        <= DIR_UP;
            r_leds       <= c_led0;
            r_step_pulse <= 1'b0;
            r_at_end     <= 1'b0;
        end else begin
            r_step_pulse <= w_tick;
            if (w_tick) begin
                r_mode   <= bus.mode;
                r_pos    <= w_pos;
                r_dir    <= w_dir;
                r_leds   <= w_leds;
                r_at_end <= w_at_end;
            end
        end
    end

    assign bus.leds       = r_leds;
    assign bus.step_pulse = r_step_pulse;
    assign bus.at_end     = r_at_end;

endmodule
`default_nettype wire
